// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared pipeline word width, encodings and fetch FSM states
package fetch_stage_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_ENC  = 16'h0800;
  localparam word_t HALT_ENC = 16'h0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Sequential PC step; 16-bit modulo by construction.
  function automatic word_t pc_plus2(input word_t pc);
    return pc + word_t'(2);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with write-enable, flush-to-bubble and valid
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_ENC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pcplus2_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pcplus2_o,
  output logic              valid_o
);

  logic [WORD_W-1:0] instr_q;
  logic [WORD_W-1:0] pcplus2_q;
  logic              valid_q;

  // Flush wins over write; neither asserted means hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q   <= NOP_INSTR;
      pcplus2_q <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      instr_q   <= NOP_INSTR;
      valid_q   <= 1'b0;
    end else if (we_i) begin
      instr_q   <= instr_i;
      pcplus2_q <= pcplus2_i;
      valid_q   <= valid_i;
    end
  end

  assign instr_o   = instr_q;
  assign pcplus2_o = pcplus2_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, memory handshake FSM, stall hold buffer, redirect and halt
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000,
  parameter logic [WORD_W-1:0] NOP_INSTR  = NOP_ENC,
  parameter logic [WORD_W-1:0] HALT_INSTR = HALT_ENC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              branch_taken_in,
  input  logic [WORD_W-1:0] branch_target_in,
  output logic [WORD_W-1:0] imem_addr_out,
  output logic              imem_rd_out,
  input  logic [WORD_W-1:0] imem_data_in,
  input  logic              imem_done_in,
  output logic [WORD_W-1:0] IF_ID_instr_out,
  output logic [WORD_W-1:0] IF_ID_PCplus2_out,
  output logic              IF_ID_valid_out,
  output logic              halt_out,
  output logic              fetch_busy_out
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              buf_valid_q, buf_valid_d;
  logic [WORD_W-1:0] buf_data_q, buf_data_d;
  logic              drop_q, drop_d;

  logic              fetch_active;
  logic              mem_done;
  logic              ifid_we;
  logic              ifid_flush;
  logic [WORD_W-1:0] ifid_instr;

  // A full hold buffer already owns the next word, so no new read is issued.
  assign fetch_active = (state_q != ST_HALTED) && !buf_valid_q;
  assign mem_done     = imem_done_in && fetch_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_data_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    drop_d      = drop_q;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    ifid_instr  = imem_data_in;

    if (branch_taken_in) begin
      pc_d        = branch_target_in;
      ifid_flush  = 1'b1;
      buf_valid_d = 1'b0;
      state_d     = ST_FETCH;
      // A read still in flight will return a stale word; remember to discard it.
      drop_d      = (drop_q || (state_q == ST_WAIT)) && !imem_done_in;
    end else if (drop_q && mem_done) begin
      drop_d     = 1'b0;
      state_d    = ST_FETCH;
      ifid_flush = !stall_in;
    end else if (stall_in) begin
      if (mem_done) begin
        buf_valid_d = 1'b1;
        buf_data_d  = imem_data_in;
        state_d     = ST_FETCH;
      end else if ((state_q == ST_FETCH) && fetch_active) begin
        state_d = ST_WAIT;
      end
    end else if (buf_valid_q || mem_done) begin
      ifid_instr  = buf_valid_q ? buf_data_q : imem_data_in;
      ifid_we     = 1'b1;
      pc_d        = pc_plus2(pc_q);
      buf_valid_d = 1'b0;
      state_d     = (ifid_instr == HALT_INSTR) ? ST_HALTED : ST_FETCH;
    end else begin
      ifid_flush = 1'b1;
      if (state_q == ST_FETCH) begin
        state_d = ST_WAIT;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (ifid_we),
    .flush_i   (ifid_flush),
    .instr_i   (ifid_instr),
    .pcplus2_i (pc_plus2(pc_q)),
    .valid_i   (1'b1),
    .instr_o   (IF_ID_instr_out),
    .pcplus2_o (IF_ID_PCplus2_out),
    .valid_o   (IF_ID_valid_out)
  );

  assign imem_addr_out  = pc_q;
  assign imem_rd_out    = rst_n && fetch_active;
  assign halt_out       = (state_q == ST_HALTED);
  assign fetch_busy_out = (state_q == ST_WAIT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a latency-programmable instruction memory
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_in = 1'b0;
  logic        branch_taken_in = 1'b0;
  logic [15:0] branch_target_in = 16'h0000;
  logic [15:0] imem_addr_out;
  logic        imem_rd_out;
  logic [15:0] imem_data_in = 16'h0000;
  logic        imem_done_in = 1'b0;
  logic [15:0] IF_ID_instr_out;
  logic [15:0] IF_ID_PCplus2_out;
  logic        IF_ID_valid_out;
  logic        halt_out;
  logic        fetch_busy_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] e_w, o_w;

  logic [15:0] prog [logic [15:0]];
  int          mem_lat = 0;
  int          mem_cnt = 0;
  int          req_cnt = 0;
  logic        in_req = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic        mon_stall, mon_br;

  fetch_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_in          (stall_in),
    .branch_taken_in   (branch_taken_in),
    .branch_target_in  (branch_target_in),
    .imem_addr_out     (imem_addr_out),
    .imem_rd_out       (imem_rd_out),
    .imem_data_in      (imem_data_in),
    .imem_done_in      (imem_done_in),
    .IF_ID_instr_out   (IF_ID_instr_out),
    .IF_ID_PCplus2_out (IF_ID_PCplus2_out),
    .IF_ID_valid_out   (IF_ID_valid_out),
    .halt_out          (halt_out),
    .fetch_busy_out    (fetch_busy_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (prog.exists(a)) return prog[a];
    return 16'h7000 | {4'h0, a[11:0]};
  endfunction

  // Memory latches the address at request start and answers mem_lat cycles later.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_req = 1'b0;
      mem_cnt = 0;
      imem_done_in = 1'b0;
    end else if (imem_rd_out || in_req) begin
      if (!in_req) begin
        in_req = 1'b1;
        req_addr = imem_addr_out;
        mem_cnt = 0;
        req_cnt++;
      end
      if (mem_cnt >= mem_lat) begin
        imem_done_in = 1'b1;
        imem_data_in = mem_word(req_addr);
        in_req = 1'b0;
      end else begin
        imem_done_in = 1'b0;
        mem_cnt++;
      end
    end else begin
      imem_done_in = 1'b0;
    end
  end

  // An edge with no stall and no redirect that leaves valid=1 is a fresh delivery.
  always @(posedge clk) begin
    mon_stall = stall_in;
    mon_br = branch_taken_in;
    #1;
    if (rst_n && !mon_stall && !mon_br && IF_ID_valid_out)
      obs_q.push_back({IF_ID_instr_out, IF_ID_PCplus2_out});
  end

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst_n = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0; branch_target_in = 16'h0000;
    mem_lat = lat;
    prog.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); req_cnt = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; stall_in = 1'b0; branch_taken_in = 1'b0;
    @(negedge clk);
    checks++; if (imem_rd_out !== 1'b0) begin errors++; $display("FAIL rst_rd: got %b want 0", imem_rd_out); end
    checks++; if (IF_ID_instr_out !== 16'h0800) begin errors++; $display("FAIL rst_instr: got %h want 0800", IF_ID_instr_out); end
    checks++; if (IF_ID_PCplus2_out !== 16'h0000) begin errors++; $display("FAIL rst_pcp2: got %h want 0000", IF_ID_PCplus2_out); end
    checks++; if (IF_ID_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", IF_ID_valid_out); end
    checks++; if ({halt_out, fetch_busy_out} !== 2'b00) begin errors++; $display("FAIL rst_halt_busy: got %b want 00", {halt_out, fetch_busy_out}); end
    checks++; if (imem_addr_out !== 16'h0000) begin errors++; $display("FAIL rst_pc: got %h want 0000", imem_addr_out); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_rd_out !== 1'b1) begin errors++; $display("FAIL rst_first_rd: got %b want 1", imem_rd_out); end
  endtask

  task automatic test_zero_wait;
    do_reset(0);
    prog[16'h0000] = 16'h4001; prog[16'h0002] = 16'h4002;
    exp_q.push_back({16'h4001, 16'h0002});
    exp_q.push_back({16'h4002, 16'h0004});
    @(negedge clk);
    @(negedge clk);
    checks++; if ({IF_ID_instr_out, IF_ID_PCplus2_out} !== {16'h4001, 16'h0002}) begin errors++; $display("FAIL zw_first: got %h want 40010002", {IF_ID_instr_out, IF_ID_PCplus2_out}); end
    @(negedge clk);
    stall_in = 1'b1;
    checks++; if (IF_ID_valid_out !== 1'b1) begin errors++; $display("FAIL zw_valid: got %b want 1", IF_ID_valid_out); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL zw_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL zw_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_wait_states;
    do_reset(3);
    prog[16'h0000] = 16'h4abc;
    exp_q.push_back({16'h4abc, 16'h0002});
    @(negedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++; if ({fetch_busy_out, imem_rd_out, IF_ID_valid_out} !== 3'b110) begin errors++; $display("FAIL ws_busy_rd_valid c%0d: got %b want 110", c, {fetch_busy_out, imem_rd_out, IF_ID_valid_out}); end
      checks++; if ({imem_addr_out, IF_ID_instr_out} !== {16'h0000, 16'h0800}) begin errors++; $display("FAIL ws_addr_nop c%0d: got %h want 00000800", c, {imem_addr_out, IF_ID_instr_out}); end
    end
    @(negedge clk);
    stall_in = 1'b1;
    checks++; if ({fetch_busy_out, imem_addr_out} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL ws_after: got %h want 0002 busy 0", {fetch_busy_out, imem_addr_out}); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ws_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL ws_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_stall;
    do_reset(0);
    prog[16'h0000] = 16'h4111; prog[16'h0002] = 16'h4222;
    exp_q.push_back({16'h4111, 16'h0002});
    exp_q.push_back({16'h4222, 16'h0004});
    @(negedge clk);
    @(negedge clk);
    stall_in = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++; if ({IF_ID_instr_out, IF_ID_PCplus2_out} !== {16'h4111, 16'h0002}) begin errors++; $display("FAIL st_hold c%0d: got %h want 41110002", c, {IF_ID_instr_out, IF_ID_PCplus2_out}); end
      checks++; if ({imem_rd_out, imem_addr_out} !== {1'b0, 16'h0002}) begin errors++; $display("FAIL st_rd_pc c%0d: got %h want rd0 0002", c, {imem_rd_out, imem_addr_out}); end
    end
    stall_in = 1'b0;
    @(negedge clk); #2;
    stall_in = 1'b1;
    checks++; if ({IF_ID_instr_out, IF_ID_PCplus2_out, IF_ID_valid_out} !== {16'h4222, 16'h0004, 1'b1}) begin errors++; $display("FAIL st_release: got %h want 4222_0004 valid", {IF_ID_instr_out, IF_ID_PCplus2_out}); end
    checks++; if (req_cnt != 3) begin errors++; $display("FAIL st_rerequest: got %0d requests want 3", req_cnt); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL st_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL st_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_redirect_wait;
    int guard;
    do_reset(3);
    prog[16'h0000] = 16'h4aaa; prog[16'h0100] = 16'h4bbb;
    exp_q.push_back({16'h4bbb, 16'h0102});
    @(negedge clk);
    @(negedge clk);
    branch_taken_in = 1'b1; branch_target_in = 16'h0100;
    @(negedge clk);
    branch_taken_in = 1'b0;
    checks++; if ({imem_rd_out, imem_addr_out} !== {1'b1, 16'h0100}) begin errors++; $display("FAIL rd_redir_addr: got %h want rd1 0100", {imem_rd_out, imem_addr_out}); end
    checks++; if ({IF_ID_valid_out, IF_ID_instr_out} !== {1'b0, 16'h0800}) begin errors++; $display("FAIL rd_redir_nop: got %h want 0 0800", {IF_ID_valid_out, IF_ID_instr_out}); end
    guard = 0;
    while (!IF_ID_valid_out && guard < 20) begin @(negedge clk); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL rd_timeout: got no delivery in %0d cycles want one", guard); end
    stall_in = 1'b1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL rd_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_halt;
    do_reset(0);
    prog[16'h0000] = 16'h4123; prog[16'h0002] = 16'h0000;
    exp_q.push_back({16'h4123, 16'h0002});
    exp_q.push_back({16'h0000, 16'h0004});
    exp_q.push_back({16'h7020, 16'h0022});
    repeat (3) @(negedge clk);
    checks++; if ({halt_out, imem_rd_out} !== 2'b10) begin errors++; $display("FAIL hl_enter: got %b want 10", {halt_out, imem_rd_out}); end
    @(negedge clk);
    checks++; if ({halt_out, imem_rd_out, imem_addr_out} !== {2'b10, 16'h0004}) begin errors++; $display("FAIL hl_frozen: got %h want 10 0004", {halt_out, imem_rd_out, imem_addr_out}); end
    checks++; if ({IF_ID_valid_out, IF_ID_instr_out} !== {1'b0, 16'h0800}) begin errors++; $display("FAIL hl_nop: got %h want 0 0800", {IF_ID_valid_out, IF_ID_instr_out}); end
    branch_taken_in = 1'b1; branch_target_in = 16'h0020;
    @(negedge clk);
    branch_taken_in = 1'b0;
    checks++; if ({halt_out, imem_rd_out, imem_addr_out} !== {2'b01, 16'h0020}) begin errors++; $display("FAIL hl_resume: got %h want 01 0020", {halt_out, imem_rd_out, imem_addr_out}); end
    @(negedge clk);
    stall_in = 1'b1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hl_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL hl_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_wrap;
    do_reset(0);
    prog[16'h0000] = 16'h4999;
    exp_q.push_back({16'h7ffe, 16'h0000});
    @(negedge clk);
    branch_taken_in = 1'b1; branch_target_in = 16'hfffe;
    @(negedge clk);
    branch_taken_in = 1'b0;
    checks++; if ({IF_ID_valid_out, imem_addr_out} !== {1'b0, 16'hfffe}) begin errors++; $display("FAIL wr_discard: got %h want 0 fffe", {IF_ID_valid_out, imem_addr_out}); end
    @(negedge clk);
    checks++; if ({IF_ID_PCplus2_out, imem_addr_out} !== {16'h0000, 16'h0000}) begin errors++; $display("FAIL wr_wrap: got %h want 00000000", {IF_ID_PCplus2_out, imem_addr_out}); end
    branch_taken_in = 1'b1; branch_target_in = 16'h0031;
    @(negedge clk);
    branch_taken_in = 1'b0;
    checks++; if (imem_addr_out !== 16'h0031) begin errors++; $display("FAIL wr_misaligned: got %h want 0031", imem_addr_out); end
    stall_in = 1'b1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL wr_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL wr_word: got %h want %h", o_w, e_w); end
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset(3);
    @(negedge clk);
    @(negedge clk);
    checks++; if (fetch_busy_out !== 1'b1) begin errors++; $display("FAIL rm_busy: got %b want 1", fetch_busy_out); end
    rst_n = 1'b0;
    #1;
    checks++; if ({imem_rd_out, fetch_busy_out, IF_ID_valid_out} !== 3'b000) begin errors++; $display("FAIL rm_abandon: got %b want 000", {imem_rd_out, fetch_busy_out, IF_ID_valid_out}); end
    do_reset(0);
    prog[16'h0000] = 16'h4555;
    exp_q.push_back({16'h4555, 16'h0002});
    @(negedge clk);
    @(negedge clk);
    stall_in = 1'b1;
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e_w = exp_q.pop_front(); o_w = obs_q.pop_front();
      checks++; if (o_w !== e_w) begin errors++; $display("FAIL rm_word: got %h want %h", o_w, e_w); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_redirect_wait();
    test_halt();
    test_wrap();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded 200000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 16'h0000, first fetch address; NOP_INSTR, default 16'h0800, bubble encoding; HALT_INSTR, default 16'h0000, halt encoding.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low. Ports SHALL be:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  hazard-detector stall; IF/ID and PC hold
- branch_taken_in  in  1  redirect request from EX
- branch_target_in  in  16  redirect PC
- imem_addr_out  out  16  instruction memory address
- imem_rd_out  out  1  instruction read request
- imem_data_in  in  16  instruction word, valid with imem_done_in
- imem_done_in  in  1  read complete this cycle
- IF_ID_instr_out  out  16  registered instruction to decode
- IF_ID_PCplus2_out  out  16  registered PC+2 of that instruction
- IF_ID_valid_out  out  1  IF/ID holds a real instruction
- halt_out  out  1  fetch halted
- fetch_busy_out  out  1  read outstanding

Function
REQ-003 The FSM SHALL have states FETCH, WAIT and HALTED.
REQ-004 In FETCH, imem_rd_out SHALL be 1 and imem_addr_out SHALL equal PC.
REQ-005 In FETCH, if imem_done_in=0, the FSM SHALL go to WAIT.
REQ-006 In WAIT, imem_rd_out SHALL stay 1 with imem_addr_out stable, and fetch_busy_out SHALL be 1, until imem_done_in=1.
REQ-007 On imem_done_in with stall_in=0 and no redirect, the block SHALL load imem_data_in into IF_ID_instr_out, load PC+2 into IF_ID_PCplus2_out and set IF_ID_valid_out=1, with the PC advancing by 2 in the same edge (zero-wait latency: 1 cycle).
REQ-008 On imem_done_in with stall_in=1, the word SHALL be captured in a one-entry hold buffer, and IF/ID and PC SHALL hold.
REQ-009 While the buffer is full, imem_rd_out SHALL be 0.
REQ-010 The buffered word SHALL be delivered per REQ-007 on the first cycle with stall_in=0.
REQ-011 While stall_in=1, IF/ID and PC SHALL hold regardless of FSM state.
REQ-012 When no word is delivered, stall_in=0 and there is no redirect, IF/ID SHALL load NOP_INSTR with IF_ID_valid_out=0.
REQ-013 A redirect SHALL have priority over stall_in: on branch_taken_in=1, PC <= branch_target_in, IF/ID <= NOP_INSTR with valid=0, the buffer SHALL clear, and the FSM SHALL go to FETCH.
REQ-014 A response outstanding in WAIT when a redirect occurs SHALL be dropped: a drop flag discards the next imem_done_in, which SHALL NOT be delivered.
REQ-015 Redirect and imem_done_in in the same cycle SHALL discard the returned word.
REQ-016 When HALT_INSTR is delivered to IF/ID, the FSM SHALL enter HALTED, halt_out SHALL be 1, imem_rd_out SHALL be 0, PC SHALL freeze, and IF/ID SHALL load NOP on the next non-stalled cycles.
REQ-017 HALTED SHALL exit only on branch_taken_in (squash of a speculative halt), going to FETCH with halt_out=0.
REQ-018 PC+2 SHALL be 16-bit modulo: 16'hFFFE wraps to 16'h0000.
REQ-019 A misaligned branch_target_in (bit0=1) SHALL be used unmodified.

Reset
REQ-020 While rst_n=0, the block SHALL hold: PC=RESET_PC, FSM=FETCH, IF_ID_instr_out=NOP_INSTR, IF_ID_PCplus2_out=0, IF_ID_valid_out=0, halt_out=0, fetch_busy_out=0, buffer empty, drop flag=0.
REQ-021 imem_rd_out SHALL be 0 during reset and SHALL assert in the first cycle after rst_n rises.
REQ-022 Reset asserted mid-WAIT SHALL abandon the outstanding read with no delivery afterwards.

Structure
REQ-023 NOP/HALT encodings, the FSM state enum and the 16-bit word width SHALL live in the shared pipeline package.
REQ-024 The IF/ID register SHALL be a sub-module, if_id_reg, with write-enable, flush and valid.

Verification
REQ-025 Reset then zero-wait memory returning 16'h4001, 16'h4002 -> IF/ID shows 4001 (PCplus2=0002) then 4002 (PCplus2=0004), valid=1.
REQ-026 Memory done after 3 cycles -> 3 NOP bubbles with valid=0, fetch_busy_out=1 for 3 cycles, imem_addr_out stable.
REQ-027 stall_in=1 for 2 cycles with done arriving in the first -> IF/ID unchanged for 2 cycles, word delivered on the cycle stall drops, no re-request.
REQ-028 branch_taken_in with target 16'h0100 while in WAIT -> late response discarded, next request at 0100, IF/ID=NOP with valid=0.
REQ-029 Fetch of 16'h0000 -> halt_out=1, imem_rd_out=0, PC frozen; then branch_taken_in to 0x0020 -> halt_out=0 and fetch resumes at 0020.
REQ-030 PC=16'hFFFE with zero-wait memory -> IF_ID_PCplus2_out=16'h0000 and the next fetch is at 16'h0000.
